// File: rtl/mdu_hilo_writer.sv
// mdu_hilo_writer
//   Iterative multiply/divide unit in EX. It produces the {HI, LO} word and
//   the write enable for the HI/LO register. It handles mult, multu, div and
//   divu. While it computes it stalls the pipeline, and it pulses hilo_we for
//   one cycle per completed operation.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       mult/div request, sampled only in IDLE
//   op          00 mult, 01 multu, 10 div, 11 divu
//   src_a       multiplicand / dividend (rs)
//   src_b       multiplier / divisor (rt)
//   flush       synchronous cancel of the in-flight operation
//   stall       combinational pipeline stall request
//   done        one-cycle completion pulse
//   hilo_we     HI/LO write enable (same as done)
//   hilo_wdata  registered {HI, LO}; holds the last result
//
// Build option
//   MDU_DIV_SHORTCUT_EN: a divide whose dividend magnitude is below the divisor
//   magnitude finishes through CALC1 instead of iterating. Results are the
//   same either way; only the latency changes.
//
// state | meaning
// IDLE  | waiting for start
// CALC1 | single-cycle multiply, divide-by-zero or short-cut divide
// DIV   | restoring divide, one quotient bit per cycle, WIDTH cycles
// DONE  | result valid, done/hilo_we pulse

module mdu_hilo_writer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 flush,
    output logic                 stall,
    output logic                 done,
    output logic                 hilo_we,
    output logic [2*WIDTH-1:0]   hilo_wdata
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC1, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;

    // Decode of the incoming request (used only in IDLE)
    logic             in_signed, in_b_zero, take_short;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;

    assign in_signed = ~op[0];
    assign in_b_zero = (src_b == '0);
    assign in_mag_a  = (in_signed & src_a[WIDTH-1]) ? -src_a : src_a;
    assign in_mag_b  = (in_signed & src_b[WIDTH-1]) ? -src_b : src_b;

`ifdef MDU_DIV_SHORTCUT_EN
    assign take_short = (in_mag_a < in_mag_b);
`else
    assign take_short = 1'b0;
`endif

    // Latched-operand helpers
    logic               q_signed, neg_quo, neg_rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;

    assign q_signed = ~op_q[0];
    assign neg_quo  = q_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_rem  = q_signed & a_q[WIDTH-1];
    // The low 2W bits of the product of the sign-extended operands are the
    // correct signed product, so a single multiplier serves both forms.
    assign ext_a    = {{WIDTH{q_signed & a_q[WIDTH-1]}}, a_q};
    assign ext_b    = {{WIDTH{q_signed & b_q[WIDTH-1]}}, b_q};
    assign product  = ext_a * ext_b;

    // One restoring step. The partial remainder stays below the divisor, so
    // the shifted value fits in WIDTH+1 bits and the top bit of the trial
    // difference is its sign.
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        count_d = count_q;
        hilo_d  = hilo_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d = op;
                        a_d  = src_a;
                        b_d  = src_b;
                        if (!op[1] || in_b_zero || take_short) begin
                            state_d = CALC1;
                        end else begin
                            state_d = DIV;
                            count_d = '0;
                            rem_d   = '0;
                            quo_d   = in_mag_a;
                            dvsr_d  = in_mag_b;
                        end
                    end
                end
                CALC1: begin
                    if (!op_q[1])
                        hilo_d = product;
                    else if (b_q == '0)
                        hilo_d = {a_q, {WIDTH{1'b1}}};
                    else
                        hilo_d = {a_q, {WIDTH{1'b0}}};
                    state_d = DONE;
                end
                DIV: begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        hilo_d  = {neg_rem ? -step_rem : step_rem,
                                   neg_quo ? -step_quo : step_quo};
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            count_q <= '0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            count_q <= count_d;
            hilo_q  <= hilo_d;
        end
    end

    assign stall      = (start & (state_q == IDLE) & ~flush) |
                        (state_q == CALC1) | (state_q == DIV);
    assign done       = (state_q == DONE) & ~flush;
    assign hilo_we    = done;
    assign hilo_wdata = hilo_q;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
module tb_mdu_hilo_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    int          checks;
    int          errors;
    logic [63:0] last_hilo;

    mdu_hilo_writer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall      (stall),
        .done       (done),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%h expected=%h", tag, what, got, exp);
        end
    endtask

    // Result from the arithmetic definition of each instruction.
    function automatic logic [63:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        r  = '0;
        case (o)
            2'd0: begin sq = sa * sb; r = sq; end
            2'd1: begin uq = ua * ub; r = uq; end
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        longint ma, mb;
        if (o < 2'd2 || b == 32'd0) return 2;
        if (o == 2'd2) begin
            ma = $signed(a);
            mb = $signed(b);
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
        end
`ifdef MDU_DIV_SHORTCUT_EN
        if (ma < mb) return 2;
`endif
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          lat, got_lat;
        logic        stall_bad;
        exp       = ref_res(o, a, b);
        lat       = ref_lat(o, a, b);
        got_lat   = 0;
        stall_bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        #1;
        chk(tag, "stall_c0", 64'(stall), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got_lat = c;
                break;
            end
            if (!stall) stall_bad = 1'b1;
        end
        chk(tag, "latency", 64'(got_lat), 64'(lat));
        chk(tag, "hilo_we", 64'(hilo_we), 64'd1);
        chk(tag, "wdata", hilo_wdata, exp);
        chk(tag, "stall_done", 64'(stall), 64'd0);
        chk(tag, "stall_busy", 64'(stall_bad), 64'd0);
        last_hilo = exp;
        @(negedge clk);
        chk(tag, "pulse_once", 64'(done), 64'd0);
    endtask

    initial begin
        int          pulses;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        checks    = 0;
        errors    = 0;
        last_hilo = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        src_a     = '0;
        src_b     = '0;
        flush     = 1'b0;

        #12;
        chk("reset", "done", 64'(done), 64'd0);
        chk("reset", "hilo_we", 64'(hilo_we), 64'd0);
        chk("reset", "wdata", hilo_wdata, 64'd0);
        chk("reset", "stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult", 2'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult", "const", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 2'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu", "const", hilo_wdata, 64'h0000_0002_FFFF_FFFA);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg", "const", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'd3, 32'd100, 32'd7);
        chk("divu", "const", hilo_wdata, 64'h0000_0002_0000_000E);
        run_op("divu0", 2'd3, 32'd5, 32'd0);
        chk("divu0", "const", hilo_wdata, 64'h0000_0005_FFFF_FFFF);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf", "const", hilo_wdata, 64'h0000_0000_8000_0000);
        run_op("divu_small", 2'd3, 32'd3, 32'd10);
        chk("divu_small", "const", hilo_wdata, 64'h0000_0003_0000_0000);
        run_op("div_small", 2'd2, 32'hFFFF_FFFD, 32'd10);
        run_op("div_negb", 2'd2, 32'd100, 32'hFFFF_FFF9);

        // flush in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd3;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_div", "done_c10", 64'(done), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_div", "stall_c11", 64'(stall), 64'd0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (hilo_we) pulses++;
        end
        chk("flush_div", "no_we", 64'(pulses), 64'd0);
        chk("flush_div", "wdata_hold", hilo_wdata, last_hilo);

        // start together with flush is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'd9;
        #1;
        chk("start_flush", "stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("start_flush", "stall_next", 64'(stall), 64'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("start_flush", "no_done", 64'(pulses), 64'd0);
        chk("start_flush", "wdata_hold", hilo_wdata, last_hilo);

        // flush while in DONE suppresses the pulse
        @(negedge clk);
        start = 1'b1; op = 2'd1; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done", "done", 64'(done), 64'd0);
        chk("flush_done", "hilo_we", 64'(hilo_we), 64'd0);
        chk("flush_done", "wdata", hilo_wdata, 64'd42);
        last_hilo = 64'd42;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_done", "idle", 64'(done | stall), 64'd0);

        // randomized operations
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: begin rb = $urandom; ra = $urandom_range(0, 50); end
                default: rb = $urandom;
            endcase
            run_op("rand", ro, ra, rb);
        end

        // reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'd2; src_a = 32'h1234_5678; src_b = 32'd5;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "wdata", hilo_wdata, 64'd0);
        chk("rst_mid", "done", 64'(done), 64'd0);
        chk("rst_mid", "stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_hilo = '0;
        run_op("after_rst", 2'd0, 32'h8000_0000, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
